// File: rtl/bcd_seven_seg_scan_if.sv
// Result handshake between the binary-to-BCD converter and the display stage.
//   bcd_in   : {hundreds, tens, ones} BCD result, 4 bits per digit
//   bcd_done : converter result-valid (pulse or level)
//   bcd_ack  : one-cycle acknowledge per captured result
// master = converter side, slave = display side.
interface bcd_seven_seg_scan_if;
  logic [11:0] bcd_in;
  logic        bcd_done;
  logic        bcd_ack;

  modport master (output bcd_in, output bcd_done, input bcd_ack);
  modport slave  (input bcd_in, input bcd_done, output bcd_ack);
endinterface

// File: rtl/bcd_seven_seg_scan.sv
// Display stage for 3-digit BCD results: captures a result on each rising edge
// of bcd_done, acknowledges it for one cycle, and time-multiplexes the three
// digits onto a common-anode, active-low seven-segment display.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of the converter handshake (bcd_in/bcd_done/bcd_ack)
//   blank_lz   : 1 blanks leading zeros in the hundreds and tens positions
//   seg        : active-low segments, bit order gfedcba
//   an         : active-low digit enables, an[0]=ones, an[1]=tens, an[2]=hundreds
module bcd_seven_seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_seven_seg_scan_if.slave  bus,
  input  logic                 blank_lz,
  output logic [6:0]           seg,
  output logic [2:0]           an
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;

  logic [11:0]      stored;
  logic             valid;
  logic             done_q;
  logic             ack_q;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  logic             capture_c;
  logic             wrap_c;
  logic [3:0]       nib_c;
  logic             blank_c;
  logic [6:0]       seg_c;
  logic [2:0]       an_c;

  // Active-low glyph for one nibble; non-decimal values show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  assign capture_c = bus.bcd_done && !done_q;
  assign wrap_c    = (div == DIV_LAST);
  assign bus.bcd_ack = ack_q;

  // Digit select, leading-zero blanking and glyph decode for the current slot.
  always_comb begin
    nib_c   = stored[3:0];
    blank_c = 1'b0;
    seg_c   = SEG_BLANK;
    an_c    = 3'b111;
    case (idx)
      2'd1: begin
        nib_c   = stored[7:4];
        blank_c = blank_lz && (stored[11:8] == 4'd0) && (stored[7:4] == 4'd0);
      end
      2'd2: begin
        nib_c   = stored[11:8];
        blank_c = blank_lz && (stored[11:8] == 4'd0);
      end
      default: ;
    endcase
    if (valid) begin
      seg_c = blank_c ? SEG_BLANK : glyph(nib_c);
      an_c  = ~(3'b001 << idx);
    end
  end

  // Capture, acknowledge, refresh divider/digit index and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored <= 12'd0;
      valid  <= 1'b0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      div    <= '0;
      idx    <= 2'd0;
      seg    <= SEG_BLANK;
      an     <= 3'b111;
    end else begin
      done_q <= bus.bcd_done;
      ack_q  <= capture_c;
      if (capture_c) begin
        stored <= bus.bcd_in;
        valid  <= 1'b1;
      end
      if (wrap_c) begin
        div <= '0;
        idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      seg <= seg_c;
      an  <= an_c;
    end
  end

endmodule
